// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - instruction decode stage: condition check, control decode, register file (optional ID_RF_BYPASS_EN)
module id_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic [31:0] Result_WB,
  input  logic        writeBackEn,
  input  logic [3:0]  Dest_wb,
  input  logic        hazard,
  input  logic [3:0]  SR,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        B,
  output logic        S,
  output logic [3:0]  EXE_CMD,
  output logic [31:0] Val_Rn,
  output logic [31:0] Val_Rm,
  output logic        imm,
  output logic [11:0] Shift_operand,
  output logic [23:0] Signed_imm_24,
  output logic [3:0]  Dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        Two_src
);

  logic [3:0]  cond;
  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic        s_bit;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_pass;
  logic        wb_raw, mr_raw, mw_raw, b_raw, s_raw;
  logic [3:0]  cmd_raw;
  logic        gate;
  logic [31:0] rf [0:14];

  assign cond   = Instruction[31:28];
  assign mode   = Instruction[27:26];
  assign opcode = Instruction[24:21];
  assign s_bit  = Instruction[20];
  assign {flag_n, flag_z, flag_c, flag_v} = SR;

  assign imm           = Instruction[25];
  assign Shift_operand = Instruction[11:0];
  assign Signed_imm_24 = Instruction[23:0];
  assign Dest          = Instruction[15:12];

  // Evaluate the condition field against the status flags
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Decode mode/opcode into raw (ungated) control bits
  always_comb begin
    wb_raw  = 1'b0;
    mr_raw  = 1'b0;
    mw_raw  = 1'b0;
    b_raw   = 1'b0;
    s_raw   = 1'b0;
    cmd_raw = 4'b0000;
    case (mode)
      2'b00: begin
        s_raw = s_bit;
        case (opcode)
          4'b1101: begin cmd_raw = 4'b0001; wb_raw = 1'b1; end
          4'b1111: begin cmd_raw = 4'b1001; wb_raw = 1'b1; end
          4'b0100: begin cmd_raw = 4'b0010; wb_raw = 1'b1; end
          4'b0101: begin cmd_raw = 4'b0011; wb_raw = 1'b1; end
          4'b0010: begin cmd_raw = 4'b0100; wb_raw = 1'b1; end
          4'b0110: begin cmd_raw = 4'b0101; wb_raw = 1'b1; end
          4'b0000: begin cmd_raw = 4'b0110; wb_raw = 1'b1; end
          4'b1100: begin cmd_raw = 4'b0111; wb_raw = 1'b1; end
          4'b0001: begin cmd_raw = 4'b1000; wb_raw = 1'b1; end
          4'b1010: cmd_raw = 4'b0100;
          4'b1000: cmd_raw = 4'b0110;
          default: s_raw = 1'b0;
        endcase
      end
      2'b01: begin
        if (opcode == 4'b0100) begin
          cmd_raw = 4'b0010;
          if (s_bit) begin
            mr_raw = 1'b1;
            wb_raw = 1'b1;
          end else begin
            mw_raw = 1'b1;
          end
        end
      end
      2'b10: b_raw = 1'b1;
      default: ;
    endcase
  end

  // A failed condition or a stall squashes every control bit
  assign gate     = cond_pass & ~hazard;
  assign WB_EN    = wb_raw & gate;
  assign MEM_R_EN = mr_raw & gate;
  assign MEM_W_EN = mw_raw & gate;
  assign B        = b_raw & gate;
  assign S        = s_raw & gate;
  assign EXE_CMD  = gate ? cmd_raw : 4'b0000;

  // Stores read Rd as their data source, so source selection uses the ungated store bit
  assign src1    = Instruction[19:16];
  assign src2    = mw_raw ? Instruction[15:12] : Instruction[3:0];
  assign Two_src = ~imm | mw_raw;

  // Register file update; reset loads each register with its own index
`ifdef ID_RF_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
`else
  always_ff @(negedge clk or posedge rst) begin
`endif
    if (rst) begin
      for (int i = 0; i < 15; i++) rf[i] <= 32'(i);
    end else if (writeBackEn) begin
      for (int i = 0; i < 15; i++)
        if (Dest_wb == 4'(i)) rf[i] <= Result_WB;
    end
  end

  // Combinational operand reads; index 15 has no storage and reads as zero
  always_comb begin
    Val_Rn = 32'h0;
    Val_Rm = 32'h0;
    for (int i = 0; i < 15; i++) begin
      if (src1 == 4'(i)) Val_Rn = rf[i];
      if (src2 == 4'(i)) Val_Rm = rf[i];
    end
`ifdef ID_RF_BYPASS_EN
    if (writeBackEn && (Dest_wb != 4'hF) && (src1 == Dest_wb)) Val_Rn = Result_WB;
    if (writeBackEn && (Dest_wb != 4'hF) && (src2 == Dest_wb)) Val_Rm = Result_WB;
`endif
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - directed self-checking bench for id_decode_stage
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instruction;
  logic [31:0] Result_WB;
  logic        writeBackEn;
  logic [3:0]  Dest_wb;
  logic        hazard;
  logic [3:0]  SR;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S;
  logic [3:0]  EXE_CMD;
  logic [31:0] Val_Rn, Val_Rm;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest, src1, src2;
  logic        Two_src;
  logic [8:0]  ctrl;

  int errors = 0;
  int checks = 0;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .Instruction(Instruction), .Result_WB(Result_WB),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .hazard(hazard), .SR(SR),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
    .EXE_CMD(EXE_CMD), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .Dest(Dest),
    .src1(src1), .src2(src2), .Two_src(Two_src)
  );

  always #5 clk = ~clk;

  // {WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD}
  assign ctrl = {WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [31:0] instr);
    Instruction = instr;
    #1;
  endtask

  // Spans both a falling and a rising edge so the write lands in either RF build
  task automatic rf_write(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    #1;
    writeBackEn = 1'b1;
    Dest_wb     = idx;
    Result_WB   = data;
    @(negedge clk);
    @(posedge clk);
    #1;
    writeBackEn = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; Instruction = 32'h0; Result_WB = 32'h0; writeBackEn = 1'b0;
    Dest_wb = 4'h0; hazard = 1'b0; SR = 4'h0;
    #2;
    // Decode and reads work during reset
    apply(32'hE0821003);
    check("rst_val_rn", Val_Rn, 32'd2);
    check("rst_val_rm", Val_Rm, 32'd3);
    check("rst_ctrl", 32'(ctrl), 32'(9'b1_0000_0010));

    // A write while reset is asserted is discarded
    writeBackEn = 1'b1; Dest_wb = 4'd7; Result_WB = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 writeBackEn = 1'b0;
    #2 rst = 1'b0;
    apply(32'hE0871003);
    check("rst_write_drop", Val_Rn, 32'd7);

    // ADD R1,R2,R3
    apply(32'hE0821003);
    check("add_ctrl", 32'(ctrl), 32'(9'b1_0000_0010));
    check("add_val_rn", Val_Rn, 32'd2);
    check("add_val_rm", Val_Rm, 32'd3);
    check("add_dest", 32'(Dest), 32'd1);
    check("add_two_src", 32'(Two_src), 32'd1);
    check("add_srcs", 32'({src1, src2}), 32'h23);

    // MOV R0,#20
    apply(32'hE3A00014);
    check("mov_ctrl", 32'(ctrl), 32'(9'b1_0000_0001));
    check("mov_imm", 32'(imm), 32'd1);
    check("mov_two_src", 32'(Two_src), 32'd0);
    check("mov_shift", 32'(Shift_operand), 32'h014);

    // EQ condition: false with Z=0, true with Z=1
    SR = 4'b0000;
    apply(32'h00821003);
    check("eq_false_ctrl", 32'(ctrl), 32'h0);
    check("eq_false_val_rn", Val_Rn, 32'd2);
    SR = 4'b0100;
    apply(32'h00821003);
    check("eq_true_ctrl", 32'(ctrl), 32'(9'b1_0000_0010));

    // More condition codes: GT with flags clear, LT with N=1 V=0, NV never
    SR = 4'b0000;
    apply(32'hC0821003);
    check("gt_ctrl", 32'(ctrl), 32'(9'b1_0000_0010));
    SR = 4'b1000;
    apply(32'hB0821003);
    check("lt_ctrl", 32'(ctrl), 32'(9'b1_0000_0010));
    apply(32'hA0821003);
    check("ge_ctrl", 32'(ctrl), 32'h0);
    apply(32'hF0821003);
    check("nv_ctrl", 32'(ctrl), 32'h0);
    SR = 4'b0000;

    // STR R1,[R2]
    apply(32'hE4821000);
    check("str_ctrl", 32'(ctrl), 32'(9'b0_0100_0010));
    check("str_src2", 32'(src2), 32'd1);
    check("str_val_rm", Val_Rm, 32'd1);
    check("str_two_src", 32'(Two_src), 32'd1);

    // LDR R1,[R2]
    apply(32'hE4921000);
    check("ldr_ctrl", 32'(ctrl), 32'(9'b1_1000_0010));
    check("ldr_src2", 32'(src2), 32'd0);

    // CMP R2,R3 with S bit set
    apply(32'hE1520003);
    check("cmp_ctrl", 32'(ctrl), 32'(9'b0_0001_0100));

    // Branch and mode 11
    apply(32'hEA000010);
    check("b_ctrl", 32'(ctrl), 32'(9'b0_0010_0000));
    check("b_imm24", 32'(Signed_imm_24), 32'h000010);
    apply(32'hEC000000);
    check("mode11_ctrl", 32'(ctrl), 32'h0);

    // Hazard squashes controls but not data
    hazard = 1'b1;
    apply(32'hE0821003);
    check("hazard_ctrl", 32'(ctrl), 32'h0);
    check("hazard_val_rn", Val_Rn, 32'd2);
    hazard = 1'b0;

    // Register file writes, top register, and index 15
    rf_write(4'd5, 32'hDEADBEEF);
    apply(32'hE0851003);
    check("wr_r5_rn", Val_Rn, 32'hDEADBEEF);
    apply(32'hE0821005);
    check("wr_r5_rm", Val_Rm, 32'hDEADBEEF);
    apply(32'hE082100E);
    check("r14_rm", Val_Rm, 32'd14);
    rf_write(4'd15, 32'hCAFEF00D);
    apply(32'hE08F100F);
    check("r15_rn", Val_Rn, 32'h0);
    check("r15_rm", Val_Rm, 32'h0);
    rf_write(4'd14, 32'h0000_ABCD);
    apply(32'hE08E1005);
    check("wr_r14_rn", Val_Rn, 32'h0000_ABCD);
    check("r5_kept", Val_Rm, 32'hDEADBEEF);

    // Asynchronous reset restores the index pattern
    #3 rst = 1'b1;
    #1;
    apply(32'hE0851003);
    check("rerst_r5", Val_Rn, 32'd5);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (single clock domain).
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: Instruction  in  32  fetched instruction from IF/ID register.
REQ-004 SHALL have: Result_WB  in  32  write-back data; writeBackEn  in  1  write enable; Dest_wb  in  4  write index.
REQ-005 SHALL have: hazard  in  1  stall request; SR  in  4  status flags {N,Z,C,V}.
REQ-006 SHALL have: WB_EN, MEM_R_EN, MEM_W_EN, B, S  out  1 each  control bits; EXE_CMD  out  4  ALU command.
REQ-007 SHALL have: Val_Rn, Val_Rm  out  32  operand values; imm  out  1  I bit (Instruction[25]).
REQ-008 SHALL have: Shift_operand  out  12  (Instruction[11:0]); Signed_imm_24  out  24  (Instruction[23:0]); Dest  out  4  (Instruction[15:12]).
REQ-009 SHALL have: src1, src2  out  4  source indices; Two_src  out  1  second-source-used flag.

Function
REQ-010 Fields SHALL be: cond=[31:28], mode=[27:26], opcode=[24:21], S bit=[20], Rn=[19:16], Rd=[15:12], Rm=[3:0].
REQ-011 Condition check on SR: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 true; 1111 false.
REQ-012 mode 00 opcode->EXE_CMD, WB_EN=1: MOV 1101->0001; MVN 1111->1001; ADD 0100->0010; ADC 0101->0011; SUB 0010->0100; SBC 0110->0101; AND 0000->0110; ORR 1100->0111; EOR 0001->1000.
REQ-013 mode 00 CMP 1010->0100 and TST 1000->0110 with WB_EN=0; other mode-00 opcodes SHALL give all-zero control.
REQ-014 mode 01 opcode 0100: S bit=1 LDR (EXE_CMD 0010, MEM_R_EN=1, WB_EN=1); S bit=0 STR (EXE_CMD 0010, MEM_W_EN=1); output S SHALL be 0 for memory ops.
REQ-015 mode 10 SHALL set B=1, EXE_CMD 0000, other controls 0; mode 11 SHALL give all-zero control.
REQ-016 S output SHALL equal Instruction[20] for mode 00.
REQ-017 When condition false or hazard=1, WB_EN, MEM_R_EN, MEM_W_EN, B, S and EXE_CMD SHALL all be 0; data fields still pass through.
REQ-018 src1=Rn; src2=Rd when MEM_W_EN (pre-gating) else Rm; Two_src = ~imm | MEM_W_EN.
REQ-019 Register file SHALL hold R0..R14 (32-bit); reads combinational; Val_Rn=RF[src1], Val_Rm=RF[src2]; index 15 reads 0, writes to 15 ignored.
REQ-020 Write RF[Dest_wb]<=Result_WB on falling clk edge when writeBackEn=1, so a same-cycle read sees new data after the falling edge.
REQ-021 All decode paths SHALL be combinational (zero latency); only the register file holds state.

Reset
REQ-022 rst=1 SHALL asynchronously set every RF[i] to value i (R0=0 ... R14=14); decode outputs follow Instruction combinationally during reset.
REQ-023 A write coinciding with rst=1 SHALL be discarded.

Configuration
REQ-024 Macro ID_RF_BYPASS_EN: when defined, RF writes occur on rising edge and a read whose index equals Dest_wb with writeBackEn=1 (and index!=15) SHALL return Result_WB combinationally; when undefined, REQ-020 applies with no bypass.

Verification
REQ-025 After reset, Instruction=0xE0821003 (ADD R1,R2,R3) -> EXE_CMD=0010, WB_EN=1, Val_Rn=2, Val_Rm=3, Dest=1, Two_src=1.
REQ-026 Instruction=0xE3A00014 (MOV R0,#20) -> EXE_CMD=0001, WB_EN=1, imm=1, Two_src=0, Shift_operand=0x014.
REQ-027 Instruction=0x00821003 with SR=0000 -> all controls 0; SR=0100 -> EXE_CMD=0010, WB_EN=1.
REQ-028 Instruction=0xE4821000 (STR) -> MEM_W_EN=1, WB_EN=0, src2=1, Val_Rm=1, Two_src=1.
REQ-029 writeBackEn=1, Dest_wb=5, Result_WB=0xDEADBEEF, then read R5 -> Val_Rn=0xDEADBEEF; Dest_wb=15 leaves reads of 15 at 0.
REQ-030 hazard=1 with 0xE0821003 -> all controls 0, Val_Rn=2 unchanged.
